// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the synchronous FIFO: clog2, pointer/count widths
// and a legality check for the depth and threshold parameters.
package fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Pointers carry one wrap bit above the RAM address; the count needs the same width.
  function automatic int ptr_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit params_ok(input int depth, input int almost_full,
                                   input int almost_empty);
    bit pow2;
    pow2 = (depth >= 4) && ((1 << clog2(depth)) == depth);
    return pow2 && (almost_empty < almost_full) && (almost_full <= depth);
  endfunction

  localparam int FIFO_DEPTH_DEFAULT = 16;
  localparam int FIFO_ADDR_W_DEFAULT = clog2(FIFO_DEPTH_DEFAULT);
  localparam int FIFO_PTR_W_DEFAULT = ptr_width(FIFO_DEPTH_DEFAULT);

endpackage

// File: rtl/dual_ram_module.sv
// Simple dual-port storage array: one write port, one registered read port.
module dual_ram_module
  import fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_DEPTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_ena,
  input  logic [clog2(P_ADDR_DEPTH)-1:0]   i_waddr,
  input  logic [P_DATA_WIDTH-1:0]          i_wdata,
  input  logic                             i_enb,
  input  logic [clog2(P_ADDR_DEPTH)-1:0]   i_raddr,
  output logic [P_DATA_WIDTH-1:0]          o_rdata
);

  logic [P_DATA_WIDTH-1:0] mem [P_ADDR_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_ena) mem[i_waddr] <= i_wdata;
  end

  // Only the read register is cleared so stale array contents never reach the output.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= '0;
    else if (i_enb) o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller: pointers, occupancy and registered status flags
// wrapped around dual_ram_module.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH   = 8,
  parameter int P_ADDR_DEPTH   = 16,
  parameter int P_ALMOST_FULL  = 14,
  parameter int P_ALMOST_EMPTY = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_wr_en,
  input  logic [P_DATA_WIDTH-1:0]            i_wr_data,
  input  logic                               i_rd_en,
  output logic [P_DATA_WIDTH-1:0]            o_rd_data,
  output logic                               o_rd_valid,
  output logic                               o_full,
  output logic                               o_empty,
  output logic                               o_almost_full,
  output logic                               o_almost_empty,
  output logic [ptr_width(P_ADDR_DEPTH)-1:0] o_data_cnt,
  output logic                               o_overflow,
  output logic                               o_underflow
);

  localparam int AW = clog2(P_ADDR_DEPTH);
  localparam int PW = ptr_width(P_ADDR_DEPTH);

  if (!params_ok(P_ADDR_DEPTH, P_ALMOST_FULL, P_ALMOST_EMPTY)) begin : g_bad_params
    $error("sync_fifo_ctrl: illegal depth or almost-full/empty thresholds");
  end

  logic [PW-1:0] wptr_q, rptr_q, cnt_q;
  logic [PW-1:0] wptr_nxt, rptr_nxt, cnt_nxt;
  logic          full_q, empty_q, afull_q, aempty_q;
  logic          full_nxt, empty_nxt, afull_nxt, aempty_nxt;
  logic          rd_valid_q, overflow_q, underflow_q;
  logic          push_acc, pop_acc;

  // Gating looks only at this cycle's registered flags, never at the opposite request.
  assign push_acc = i_wr_en & ~full_q;
  assign pop_acc  = i_rd_en & ~empty_q;

  always_comb begin
    wptr_nxt   = wptr_q + PW'(push_acc);
    rptr_nxt   = rptr_q + PW'(pop_acc);
    cnt_nxt    = cnt_q + PW'(push_acc) - PW'(pop_acc);
    full_nxt   = (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
    empty_nxt  = (wptr_nxt == rptr_nxt);
    afull_nxt  = (cnt_nxt >= PW'(P_ALMOST_FULL));
    aempty_nxt = (cnt_nxt <= PW'(P_ALMOST_EMPTY));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_nxt;
      rptr_q      <= rptr_nxt;
      cnt_q       <= cnt_nxt;
      full_q      <= full_nxt;
      empty_q     <= empty_nxt;
      afull_q     <= afull_nxt;
      aempty_q    <= aempty_nxt;
      rd_valid_q  <= pop_acc;
      overflow_q  <= i_wr_en & full_q;
      underflow_q <= i_rd_en & empty_q;
    end
  end

  dual_ram_module #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_DEPTH (P_ADDR_DEPTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ena   (push_acc & ~i_rst),
    .i_waddr (wptr_q[AW-1:0]),
    .i_wdata (i_wr_data),
    .i_enb   (pop_acc & ~i_rst),
    .i_raddr (rptr_q[AW-1:0]),
    .o_rdata (o_rd_data)
  );

  assign o_rd_valid     = rd_valid_q;
  assign o_full         = full_q;
  assign o_empty        = empty_q;
  assign o_almost_full  = afull_q;
  assign o_almost_empty = aempty_q;
  assign o_data_cnt     = cnt_q;
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Synchronous single-clock FIFO built around dual_ram_module, which it instantiates as its storage array. It owns write/read pointers, occupancy count and status flags. It drives the RAM's i_ena/i_waddr/i_wdata from accepted pushes and i_enb/i_raddr from accepted pops. It is the stage that feeds dual_ram_module in every FIFO path of the design.

Parameters:
P_DATA_WIDTH, 8, data word width, passed to dual_ram_module.
P_ADDR_DEPTH, 16, number of entries; power of 2 and at least 4; passed to dual_ram_module.
P_ALMOST_FULL, 14, o_almost_full asserts when count >= this value.
P_ALMOST_EMPTY, 2, o_almost_empty asserts when count <= this value.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active high
i_wr_en  in  1  push request
i_wr_data  in  P_DATA_WIDTH  push data
i_rd_en  in  1  pop request
o_rd_data  out  P_DATA_WIDTH  popped data, qualified by o_rd_valid
o_rd_valid  out  1  one-cycle pulse; o_rd_data holds the popped word
o_full  out  1  count == P_ADDR_DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count >= P_ALMOST_FULL
o_almost_empty  out  1  count <= P_ALMOST_EMPTY
o_data_cnt  out  clog2(P_ADDR_DEPTH)+1  current occupancy
o_overflow  out  1  one-cycle pulse: push attempted while full
o_underflow  out  1  one-cycle pulse: pop attempted while empty

Behaviour:
- One clock domain (i_clk). i_rst is synchronous and active high, and is sampled only on the i_clk rising edge.
- Reset values:
  - write and read pointers = 0; count = 0
  - o_empty = 1; o_almost_empty = 1
  - o_full = 0; o_almost_full = 0
  - o_rd_valid = 0; o_rd_data = 0
  - o_overflow = 0; o_underflow = 0
- Reset mid-operation discards all contents. A pop in flight during reset produces no o_rd_valid. Stale RAM contents are never exposed.
- Pointers are clog2(P_ADDR_DEPTH)+1 bits wide, with an extra wrap bit. The RAM address is the low clog2 bits, which wrap from P_ADDR_DEPTH-1 to 0.
- Full means the address bits are equal and the wrap bits differ. Empty means the pointers are equal.
- Push accepted = i_wr_en & ~o_full. Same cycle: drive RAM i_ena=1, i_waddr=wptr[addr], i_wdata=i_wr_data. Write pointer increments at the next edge.
- Pop accepted = i_rd_en & ~o_empty. Same cycle: drive RAM i_enb=1, i_raddr=rptr[addr]. Read pointer increments at the next edge.
- Read latency: dual_ram_module registers o_rdata one cycle after i_enb. o_rd_valid pulses the cycle after pop acceptance. o_rd_data shows the RAM output and holds its value when o_rd_valid = 0.
- Flag gating uses only the registered flags of the current cycle:
  - Push while full is dropped, even if a pop is accepted in the same cycle.
  - Pop while empty is dropped, even if a push is accepted in the same cycle.
- Count update: count += (push accepted) - (pop accepted). A simultaneous accepted push and pop leaves count unchanged.
- o_full, o_empty, o_almost_full and o_almost_empty are registered. They reflect the count after the edge, so a flag changes in the cycle following the push/pop that caused it.
- o_overflow = registered (i_wr_en & o_full). o_underflow = registered (i_rd_en & o_empty). Each is a one-cycle pulse per offending cycle.
- No other state machine is needed. The controller is two pointer counters, the occupancy counter and the flag registers.

Decomposition:
- Shared package / include fifo_pkg:
  - clog2 function
  - pointer-width and count-width localparams derived from P_ADDR_DEPTH
  - parameter legality checks: power of 2, P_ALMOST_EMPTY < P_ALMOST_FULL <= P_ADDR_DEPTH
- One sub-module: dual_ram_module, instantiated as the storage array. The controller logic stays flat in sync_fifo_ctrl.

Test Plan:
- Reset: hold i_rst for 5 cycles -> o_empty=1, o_full=0, o_data_cnt=0, o_rd_valid=0, o_almost_empty=1.
- Fill and drain, defaults (16 deep): push 16 words 1..16, then pop 16.
  - o_full=1 the cycle after the 16th push; o_almost_full=1 after the 14th.
  - Pops return 1..16 in order, each with o_rd_valid one cycle after its pop.
  - o_empty=1 after the last pop.
- Overflow/underflow:
  - Push a 17th word (0xAA) while full -> o_overflow pulses once, o_data_cnt stays 16, 0xAA never appears on o_rd_data.
  - Pop while empty -> o_underflow pulses, no o_rd_valid.
- Simultaneous push/pop: with count=5, assert both for 20 cycles -> o_data_cnt stays 5, output order is preserved, and the pointers wrap past address 15 without data corruption.
- Boundary simultaneity:
  - Empty plus push and pop in the same cycle -> only the push is taken, count=1, no o_rd_valid.
  - Full plus push and pop in the same cycle -> only the pop is taken, count=15.
- Reset mid-operation: push 6 words, assert i_rst for 1 cycle while a pop is issued -> no o_rd_valid pulse, o_data_cnt=0, o_empty=1; the next push/pop pair returns the newly written word.
